pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
Next-PC controller that sequences the 16-bit program counter register. Each cycle it selects among sequential increment, taken branch, jump, call/return and interrupt entry, and it handles stall and halt. It drives the PC register's write port (pc_in, pc_write_enable) and mirrors the committed PC. It sits between decode/execute control and the PC register in the fetch path.

Parameters:
WIDTH, 16, PC width in bits
RESET_VECTOR, 16'h0000, PC value after reset
IRQ_VECTOR, 16'h0100, PC loaded on interrupt entry
RAS_DEPTH, 4, return-address stack entries (power of 2, 2..16)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
stall  in  1  hold PC this cycle
branch_taken  in  1  conditional branch resolved taken
branch_target  in  WIDTH  branch destination
jump  in  1  unconditional jump
call  in  1  jump and push return address (pc+1)
jump_target  in  WIDTH  destination for jump/call
ret  in  1  pop return address into PC
irq  in  1  interrupt request (level)
irq_done  in  1  end of ISR: re-enable interrupts
halt  in  1  enter HALT state
resume  in  1  leave HALT state
pc_in  out  WIDTH  next-PC value to PC register
pc_write_enable  out  1  load strobe to PC register
pc  out  WIDTH  current committed PC (internal mirror)
irq_ack  out  1  one-cycle pulse on interrupt entry
halted  out  1  high in HALT state
ras_overflow  out  1  sticky: push while stack full
ras_underflow  out  1  sticky: pop while stack empty

Behaviour:
- Reset (reset=0, async): pc=RESET_VECTOR, pc_in=RESET_VECTOR, pc_write_enable=0, irq_ack=0, halted=0, both sticky flags=0, stack empty, irq_enable=1, state=BOOT.
- States: BOOT -> RUN (one cycle, pc_write_enable=1 with pc_in=RESET_VECTOR); RUN; HALT.
- RUN, priority per cycle: halt > stall > irq(irq_enable=1) > ret > call > jump > branch_taken > increment.
- next_pc: increment pc+1 mod 2^WIDTH (0xFFFF -> 0x0000, no flag); branch -> branch_target; jump -> jump_target; call -> jump_target and push pc+1; ret -> pop; irq -> IRQ_VECTOR, push pc (the interrupted instruction), irq_ack=1, irq_enable=0.
- pc_in/pc_write_enable are registered outputs; pc updates on the same edge. Latency: control sampled at edge N, new pc visible after edge N.
- stall=1: pc_write_enable=0, pc holds, stack untouched, irq held off (irq is level, so it is taken after stall drops).
- irq_done=1 sets irq_enable=1 (independent of stall). ret does not re-enable interrupts.
- halt=1 in RUN: -> HALT, halted=1, pc holds, no writes. In HALT, resume=1 -> RUN, and next cycle increments. irq is ignored while halted.
- RAS: push when full drops the oldest entry (circular), sets ras_overflow. Pop when empty returns RESET_VECTOR and sets ras_underflow. Flags clear only on reset.
- Simultaneous call+ret: ret wins and no push occurs. Simultaneous jump+branch_taken: jump wins.
- Reset mid-operation aborts immediately. Stack contents are discarded.

Optional Feature:
PC_SEQ_RAS_EN. When defined: the return-address stack is implemented as above. When undefined: no stack. call behaves as jump. ret behaves as increment. irq entry does not save pc. ras_overflow and ras_underflow are tied to 0. RAS_DEPTH is unused.

Test Plan:
- Release reset, then 4 idle cycles -> BOOT writes 0x0000, then pc = 0x0001, 0x0002, 0x0003, 0x0004; pc_write_enable=1 each cycle.
- At pc=0x0003: stall for 2 cycles, then branch_taken with target 0x1234 -> pc holds at 0x0003 for 2 cycles, then 0x1234, then 0x1235.
- At pc=0x0010: call to 0x0200, run 2 cycles, then ret -> 0x0200, 0x0201, 0x0202, then 0x0011. Then ret again -> 0x0000 and ras_underflow=1.
- Perform 5 nested calls with RAS_DEPTH=4 -> ras_overflow=1; 4 pops return the newest 4 addresses in LIFO order.
- irq at pc=0x0050 -> pc=0x0100 and irq_ack pulses once. A second irq is ignored until irq_done; ret then returns to 0x0050.
- Drive pc to 0xFFFF, then increment -> 0x0000. halt -> halted=1 and pc frozen for 3 cycles; resume -> increment continues. Assert reset mid-run -> pc=0x0000 immediately.

Source files
------------

// File: rtl/pc_sequencer.sv
// Next-PC controller: increment/branch/jump/call/return/interrupt, stall and halt.
// Define PC_SEQ_RAS_EN to build the return-address stack; without it call acts as jump and ret as increment.
//   state  | meaning
//   S_BOOT | first cycle after reset, writes RESET_VECTOR
//   S_RUN  | normal sequencing
//   S_HALT | PC frozen until resume
module pc_sequencer #(
  parameter int                WIDTH        = 16,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = 16'h0000,
  parameter logic [WIDTH-1:0]  IRQ_VECTOR   = 16'h0100,
  parameter int                RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic             call,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             ret,
  input  logic             irq,
  input  logic             irq_done,
  input  logic             halt,
  input  logic             resume,
  output logic [WIDTH-1:0] pc_in,
  output logic             pc_write_enable,
  output logic [WIDTH-1:0] pc,
  output logic             irq_ack,
  output logic             halted,
  output logic             ras_overflow,
  output logic             ras_underflow
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

`ifdef PC_SEQ_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pc_nxt, pc_inc, push_val, pop_val;
  logic             we_nxt, ack_nxt, irq_enable, irq_en_nxt, push, pop;

  assign pc_inc = pc + WIDTH'(1);
  assign halted = (state == S_HALT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= S_BOOT;
      pc              <= RESET_VECTOR;
      pc_in           <= RESET_VECTOR;
      pc_write_enable <= 1'b0;
      irq_ack         <= 1'b0;
      irq_enable      <= 1'b1;
    end else begin
      state           <= state_nxt;
      pc              <= pc_nxt;
      pc_in           <= pc_nxt;
      pc_write_enable <= we_nxt;
      irq_ack         <= ack_nxt;
      irq_enable      <= irq_en_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    we_nxt     = 1'b0;
    ack_nxt    = 1'b0;
    irq_en_nxt = irq_enable | irq_done;
    push       = 1'b0;
    pop        = 1'b0;
    push_val   = pc_inc;
    case (state)
      S_BOOT: begin
        state_nxt = S_RUN;
        pc_nxt    = RESET_VECTOR;
        we_nxt    = 1'b1;
      end
      S_RUN: begin
        if (halt) begin
          state_nxt = S_HALT;
        end else if (!stall) begin
          we_nxt = 1'b1;
          if (irq && irq_enable) begin
            // the interrupted instruction is saved so ret re-executes it
            pc_nxt     = IRQ_VECTOR;
            ack_nxt    = 1'b1;
            irq_en_nxt = 1'b0;
            push       = RAS_EN;
            push_val   = pc;
          end else if (ret) begin
            pop    = RAS_EN;
            pc_nxt = RAS_EN ? pop_val : pc_inc;
          end else if (call) begin
            push   = RAS_EN;
            pc_nxt = jump_target;
          end else if (jump) begin
            pc_nxt = jump_target;
          end else if (branch_taken) begin
            pc_nxt = branch_target;
          end else begin
            pc_nxt = pc_inc;
          end
        end
      end
      S_HALT: begin
        if (resume) state_nxt = S_RUN;
      end
      default: state_nxt = S_BOOT;
    endcase
  end

`ifdef PC_SEQ_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;

  assign pop_val = (count == '0) ? RESET_VECTOR : ras[wr_ptr - PW'(1)];

  // circular buffer: a push while full overwrites the oldest entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr        <= '0;
      count         <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PW'(1);
      if (count == CW'(RAS_DEPTH)) ras_overflow <= 1'b1;
      else                         count        <= count + CW'(1);
    end else if (pop) begin
      if (count == '0) begin
        ras_underflow <= 1'b1;
      end else begin
        wr_ptr <= wr_ptr - PW'(1);
        count  <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) ras[wr_ptr] <= push_val;
  end
`else
  logic unused_ras;
  assign pop_val       = RESET_VECTOR;
  assign ras_overflow  = 1'b0;
  assign ras_underflow = 1'b0;
  assign unused_ras    = push | pop | (^push_val) | (RAS_DEPTH != 0);
`endif

endmodule
